snax_csr_req_buffer: RTL and testbench



---
 rtl/snax_csr_buf_pkg.sv | 16 +
 rtl/snax_csr_req_buffer_if.sv | 31 +++
 rtl/snax_sync_fifo.sv | 68 ++++++
 rtl/snax_csr_req_buffer.sv | 109 ++++++++++
 tb/tb_snax_csr_req_buffer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snax_csr_buf_pkg.sv
// Shared types and default sizing for the SNAX CSR request buffer.
// csr_req_t is the request record that travels through the request FIFO.
package snax_csr_buf_pkg;

    localparam int DataWidth         = 32;
    localparam int AddrWidth         = 32;
    localparam int DefReqDepth       = 4;
    localparam int DefMaxOutstanding = 4;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [AddrWidth-1:0] addr;
        logic                 write;
    } csr_req_t;

endpackage

// File: rtl/snax_csr_req_buffer_if.sv
// SNAX CSR request/response port: a request channel and a read-response channel.
// Handshake: a beat transfers on a rising edge where valid && ready; once raised, valid holds and its payload stays stable until that edge.
interface snax_csr_req_buffer_if #(
    parameter int DataWidth = snax_csr_buf_pkg::DataWidth,
    parameter int AddrWidth = snax_csr_buf_pkg::AddrWidth
);

    logic [DataWidth-1:0] req_data;
    logic [AddrWidth-1:0] req_addr;
    logic                 req_write;
    logic                 req_valid;
    logic                 req_ready;
    logic [DataWidth-1:0] rsp_data;
    logic                 rsp_valid;
    logic                 rsp_ready;

    modport master (
        output req_data, req_addr, req_write, req_valid,
        input  req_ready,
        input  rsp_data, rsp_valid,
        output rsp_ready
    );

    modport slave (
        input  req_data, req_addr, req_write, req_valid,
        output req_ready,
        output rsp_data, rsp_valid,
        input  rsp_ready
    );

endinterface

// File: rtl/snax_sync_fifo.sv
// Generic synchronous FIFO: no fall-through, full/empty/count, synchronous active-high reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module snax_sync_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  logic [Width-1:0]           i_data,
    input  logic                       i_pop,
    output logic [Width-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(Depth+1)-1:0] o_count
);

    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [IdxW:0]    r_wptr;
    logic [IdxW:0]    r_rptr;
    logic [IdxW-1:0]  w_widx;
    logic [IdxW-1:0]  w_ridx;
    logic [IdxW-1:0]  w_diff;
    logic             w_do_push;
    logic             w_do_pop;

    // Wrap at Depth-1 explicitly so a single-entry FIFO still toggles only the wrap bit.
    function automatic logic [IdxW:0] next_ptr(input logic [IdxW:0] p);
        if (p[IdxW-1:0] == IdxW'(Depth - 1)) begin
            return {~p[IdxW], {IdxW{1'b0}}};
        end
        return p + (IdxW + 1)'(1);
    endfunction

    assign w_widx    = r_wptr[IdxW-1:0];
    assign w_ridx    = r_rptr[IdxW-1:0];
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[IdxW] != r_rptr[IdxW]) && (w_widx == w_ridx);
    assign w_diff    = w_widx - w_ridx;
    assign o_count   = o_full ? CntW'(Depth) : CntW'(w_diff);
    assign o_data    = o_empty ? '0 : r_mem[w_ridx];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[w_widx] <= i_data;
        end
    end

endmodule

// File: rtl/snax_csr_req_buffer.sv
// Elastic buffer between the translator's CSR port (up) and an accelerator CSR port (dn).
// Reads are issued only while a response slot is reserved for them, so the response FIFO cannot overflow.
module snax_csr_req_buffer #(
    parameter int DataWidth      = snax_csr_buf_pkg::DataWidth,
    parameter int AddrWidth      = snax_csr_buf_pkg::AddrWidth,
    parameter int ReqDepth       = snax_csr_buf_pkg::DefReqDepth,
    parameter int MaxOutstanding = snax_csr_buf_pkg::DefMaxOutstanding
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    snax_csr_req_buffer_if.slave  up,
    snax_csr_req_buffer_if.master dn,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int ReqW    = DataWidth + AddrWidth + 1;
    localparam int CredW   = $clog2(MaxOutstanding + 1);
    localparam int ReqCntW = $clog2(ReqDepth + 1);
    localparam int RspCntW = $clog2(MaxOutstanding + 1);

    logic [ReqW-1:0]    w_req_in;
    logic [ReqW-1:0]    w_req_head;
    logic               w_req_full;
    logic               w_req_empty;
    logic               w_req_push;
    logic               w_req_pop;
    logic [ReqCntW-1:0] w_req_count_unused;
    logic               w_head_write;
    logic               w_can_issue;
    logic               w_rd_issue;
    logic               w_rsp_full;
    logic               w_rsp_empty;
    logic               w_rsp_push;
    logic               w_rsp_pop;
    logic [RspCntW-1:0] w_rsp_count_unused;
    logic [CredW-1:0]   r_cred;
    logic               r_err;

    assign w_req_in      = {up.req_write, up.req_addr, up.req_data};
    assign up.req_ready  = !w_req_full;
    assign w_req_push    = up.req_valid && !w_req_full;

    snax_sync_fifo #(
        .Width (ReqW),
        .Depth (ReqDepth)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_req_push),
        .i_data  (w_req_in),
        .i_pop   (w_req_pop),
        .o_data  (w_req_head),
        .o_full  (w_req_full),
        .o_empty (w_req_empty),
        .o_count (w_req_count_unused)
    );

    // A read at the head without a credit blocks everything behind it to keep strict order.
    assign w_head_write  = w_req_head[ReqW-1];
    assign w_can_issue   = !w_req_empty && (w_head_write || (r_cred < CredW'(MaxOutstanding)));
    assign dn.req_valid  = w_can_issue;
    assign dn.req_write  = w_head_write;
    assign dn.req_addr   = w_req_head[DataWidth +: AddrWidth];
    assign dn.req_data   = w_req_head[DataWidth-1:0];
    assign w_req_pop     = w_can_issue && dn.req_ready;
    assign w_rd_issue    = w_req_pop && !w_head_write;

    // A response arriving with no read outstanding is dropped rather than queued.
    assign dn.rsp_ready  = !w_rsp_full;
    assign w_rsp_push    = dn.rsp_valid && !w_rsp_full && (r_cred != '0);
    assign up.rsp_valid  = !w_rsp_empty;
    assign w_rsp_pop     = !w_rsp_empty && up.rsp_ready;

    snax_sync_fifo #(
        .Width (DataWidth),
        .Depth (MaxOutstanding)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_rsp_push),
        .i_data  (dn.rsp_data),
        .i_pop   (w_rsp_pop),
        .o_data  (up.rsp_data),
        .o_full  (w_rsp_full),
        .o_empty (w_rsp_empty),
        .o_count (w_rsp_count_unused)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cred <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_rd_issue && !w_rsp_pop) begin
                r_cred <= r_cred + CredW'(1);
            end else if (!w_rd_issue && w_rsp_pop) begin
                r_cred <= r_cred - CredW'(1);
            end
            if (dn.rsp_valid && (r_cred == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_o = !w_req_empty || (r_cred != '0);
    assign err_o  = r_err;

endmodule

// File: tb/tb_snax_csr_req_buffer.sv
// Directed bench for snax_csr_req_buffer: in-order request and response scoreboards plus
// hand-computed checks of credits, back-pressure, error flag and reset behaviour.
module tb_snax_csr_req_buffer;
    import snax_csr_buf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int n_rd     = 0;
    int n_rsp    = 0;
    int base;

    logic [64:0] exp_q[$];
    logic [31:0] rsp_q[$];

    snax_csr_req_buffer_if #(.DataWidth(32), .AddrWidth(32)) up_if ();
    snax_csr_req_buffer_if #(.DataWidth(32), .AddrWidth(32)) dn_if ();

    snax_csr_req_buffer #(
        .DataWidth      (32),
        .AddrWidth      (32),
        .ReqDepth       (4),
        .MaxOutstanding (4)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .up     (up_if),
        .dn     (dn_if),
        .busy_o (busy),
        .err_o  (err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshakes are decided by values stable from the negedge to the next posedge.
    always @(negedge clk) begin
        if (!rst && dn_if.req_valid && dn_if.req_ready) begin
            n_hs++;
            if (!dn_if.req_write) n_rd++;
            if (exp_q.size() == 0) check("dn_unexpected", 1, 0);
            else check("dn_req", {dn_if.req_data, dn_if.req_addr, dn_if.req_write}, exp_q.pop_front());
        end
        if (!rst && up_if.rsp_valid && up_if.rsp_ready) begin
            n_rsp++;
            if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("up_rsp", up_if.rsp_data, rsp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst               = 1'b1;
        up_if.req_valid   = 1'b0;
        up_if.req_write   = 1'b0;
        up_if.req_addr    = '0;
        up_if.req_data    = '0;
        up_if.rsp_ready   = 1'b0;
        dn_if.req_ready   = 1'b0;
        dn_if.rsp_valid   = 1'b0;
        dn_if.rsp_data    = '0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        rsp_q.delete();
    endtask

    task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        csr_req_t e;
        logic ok;
        ok = 1'b0;
        up_if.req_valid = 1'b1;
        up_if.req_write = w;
        up_if.req_addr  = a;
        up_if.req_data  = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = up_if.req_ready;
            tick();
        end
        up_if.req_valid = 1'b0;
        if (ok) begin
            e = '{data: d, addr: a, write: w};
            exp_q.push_back(e);
        end else begin
            check("push_timeout", 0, 1);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_dn_req_valid", dn_if.req_valid, 0);
        check("rst_up_rsp_valid", up_if.rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_up_req_ready", up_if.req_ready, 1);
        check("rst_dn_rsp_ready", dn_if.rsp_ready, 1);
        check("rst_err", err, 0);
        check("rst_dn_req_data", dn_if.req_data, 0);
        check("rst_dn_req_addr", dn_if.req_addr, 0);
        check("rst_up_rsp_data", up_if.rsp_data, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        @(negedge clk);
        check_reset_vals();

        // single write, no fall-through, no response
        do_reset();
        up_if.req_valid = 1'b1;
        up_if.req_write = 1'b1;
        up_if.req_addr  = 32'h3C0;
        up_if.req_data  = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_no_fallthru", dn_if.req_valid, 0);
        check("t1_ready", up_if.req_ready, 1);
        tick();
        up_if.req_valid = 1'b0;
        exp_q.push_back({32'hDEADBEEF, 32'h3C0, 1'b1});
        @(negedge clk);
        check("t1_valid", dn_if.req_valid, 1);
        check("t1_write", dn_if.req_write, 1);
        check("t1_addr", dn_if.req_addr, 32'h3C0);
        check("t1_data", dn_if.req_data, 32'hDEADBEEF);
        check("t1_busy", busy, 1);
        tick();
        dn_if.req_ready = 1'b1;
        tick();
        dn_if.req_ready = 1'b0;
        @(negedge clk);
        check("t1_valid_after", dn_if.req_valid, 0);
        check("t1_busy_after", busy, 0);
        check("t1_no_rsp", up_if.rsp_valid, 0);

        // six reads against four credits
        do_reset();
        dn_if.req_ready = 1'b1;
        base = n_rd;
        for (int i = 0; i < 6; i++) push_req(1'b0, 32'h100 + 32'(i * 4), 32'h0);
        repeat (3) tick();
        @(negedge clk);
        check("t2_issued4", n_rd - base, 4);
        check("t2_stalled", dn_if.req_valid, 0);
        check("t2_head_addr", dn_if.req_addr, 32'h110);
        check("t2_busy", busy, 1);
        tick();
        dn_if.rsp_valid = 1'b1;
        dn_if.rsp_data  = 32'h55;
        rsp_q.push_back(32'h55);
        @(negedge clk);
        check("t2_dn_rsp_ready", dn_if.rsp_ready, 1);
        tick();
        dn_if.rsp_valid = 1'b0;
        @(negedge clk);
        check("t2_up_rsp_valid", up_if.rsp_valid, 1);
        check("t2_up_rsp_data", up_if.rsp_data, 32'h55);
        check("t2_still_stalled", dn_if.req_valid, 0);
        tick();
        up_if.rsp_ready = 1'b1;
        tick();
        up_if.rsp_ready = 1'b0;
        @(negedge clk);
        check("t2_released", dn_if.req_valid, 1);
        check("t2_rel_addr", dn_if.req_addr, 32'h110);
        tick();
        @(negedge clk);
        check("t2_issued5", n_rd - base, 5);
        check("t2_r6_stalled", dn_if.req_valid, 0);

        // request FIFO fill with downstream stalled
        do_reset();
        for (int i = 0; i < 4; i++) push_req(1'b1, 32'h200 + 32'(i * 4), 32'hA0 + 32'(i));
        @(negedge clk);
        check("t3_full_ready", up_if.req_ready, 0);
        check("t3_busy", busy, 1);
        check("t3_head_valid", dn_if.req_valid, 1);
        tick();
        dn_if.req_ready = 1'b1;
        push_req(1'b1, 32'h210, 32'hA4);
        repeat (8) tick();
        @(negedge clk);
        check("t3_drained", exp_q.size(), 0);
        check("t3_idle", busy, 0);
        check("t3_ready_back", up_if.req_ready, 1);

        // three responses against a toggling upstream ready
        do_reset();
        dn_if.req_ready = 1'b1;
        base = n_rsp;
        for (int i = 0; i < 3; i++) push_req(1'b0, 32'h300 + 32'(i * 4), 32'h0);
        repeat (3) tick();
        for (int c = 0; c < 10; c++) begin
            up_if.rsp_ready = c[0];
            if (c < 3) begin
                dn_if.rsp_valid = 1'b1;
                dn_if.rsp_data  = 32'h11 * 32'(c + 1);
                rsp_q.push_back(32'h11 * 32'(c + 1));
            end else begin
                dn_if.rsp_valid = 1'b0;
            end
            tick();
        end
        up_if.rsp_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("t4_delivered", n_rsp - base, 3);
        check("t4_rsp_q_empty", rsp_q.size(), 0);
        check("t4_rsp_idle", up_if.rsp_valid, 0);
        check("t4_credits_zero", busy, 0);

        // spurious response with no credit
        do_reset();
        dn_if.rsp_valid = 1'b1;
        dn_if.rsp_data  = 32'h77;
        @(negedge clk);
        check("t5_err_before", err, 0);
        tick();
        dn_if.rsp_valid = 1'b0;
        @(negedge clk);
        check("t5_err_set", err, 1);
        check("t5_no_rsp", up_if.rsp_valid, 0);
        check("t5_not_busy", busy, 0);
        repeat (3) tick();
        @(negedge clk);
        check("t5_err_sticky", err, 1);
        do_reset();
        @(negedge clk);
        check("t5_err_cleared", err, 0);

        // reset with queued requests and reads in flight
        do_reset();
        dn_if.req_ready = 1'b1;
        push_req(1'b0, 32'h400, 32'h0);
        push_req(1'b0, 32'h404, 32'h0);
        tick();
        tick();
        dn_if.req_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_req(1'b1, 32'h500 + 32'(i * 4), 32'hB0 + 32'(i));
        @(negedge clk);
        check("t6_busy", busy, 1);
        check("t6_queued", dn_if.req_valid, 1);
        do_reset();
        @(negedge clk);
        check_reset_vals();
        tick();
        dn_if.req_ready = 1'b1;
        up_if.rsp_ready = 1'b1;
        base = n_hs;
        repeat (6) tick();
        @(negedge clk);
        check("t6_nothing_emitted", n_hs - base, 0);
        check("t6_no_rsp", up_if.rsp_valid, 0);
        check("t6_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
